// File: rtl/periodic_strobe_generator.sv
// periodic_strobe_generator: per-channel programmable periodic strobes and square waves,
// plus a free-running cycle counter with a wrap pulse.
module periodic_strobe_generator #(
    parameter int CHANNEL_COUNT       = 4,
    parameter int CHANNEL_INDEX_WIDTH = 2,
    parameter int PERIOD_WIDTH        = 16,
    parameter int CYCLE_WIDTH         = 32
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           config_valid_i,
    output logic                           config_ready_o,
    input  logic [CHANNEL_INDEX_WIDTH-1:0] config_channel_i,
    input  logic [PERIOD_WIDTH-1:0]        config_period_i,
    input  logic [PERIOD_WIDTH-1:0]        config_phase_i,
    input  logic                           config_enable_i,
    input  logic                           sync_restart_i,
    output logic [CHANNEL_COUNT-1:0]       strobe_o,
    output logic [CHANNEL_COUNT-1:0]       toggle_o,
    output logic [CYCLE_WIDTH-1:0]         cycle_o,
    output logic                           cycle_wrap_o
);
    logic                   ready_q;
    logic                   accept;
    logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;
    logic                   wrap_q, wrap_d;

    assign accept         = config_valid_i && ready_q;
    assign config_ready_o = ready_q;
    assign cycle_o        = cycle_q;
    assign cycle_wrap_o   = wrap_q;

    genvar i;
    generate
        for (i = 0; i < CHANNEL_COUNT; i++) begin : g_ch
            logic                    running_q, running_d;
            logic                    strobe_q, strobe_d;
            logic                    toggle_q, toggle_d;
            logic [PERIOD_WIDTH-1:0] period_q, period_d;
            logic [PERIOD_WIDTH-1:0] phase_q, phase_d;
            logic [PERIOD_WIDTH-1:0] count_q, count_d;
            logic                    hit, zero;

            assign hit  = accept && (config_channel_i == CHANNEL_INDEX_WIDTH'(i));
            assign zero = (count_q == '0);

            // an accept on this channel takes priority over a simultaneous sync_restart
            always_comb begin
                running_d = running_q;
                period_d  = period_q;
                phase_d   = phase_q;
                count_d   = count_q;
                strobe_d  = 1'b0;
                toggle_d  = toggle_q;
                if (hit) begin
                    period_d  = config_period_i;
                    phase_d   = config_phase_i;
                    count_d   = config_phase_i;
                    toggle_d  = 1'b0;
                    running_d = config_enable_i && (config_period_i != '0);
                end else if (running_q && sync_restart_i) begin
                    count_d  = phase_q;
                    toggle_d = 1'b0;
                end else if (running_q) begin
                    strobe_d = zero;
                    toggle_d = toggle_q ^ zero;
                    count_d  = zero ? period_q - PERIOD_WIDTH'(1) : count_q - PERIOD_WIDTH'(1);
                end
            end

            always_ff @(posedge clock_i or posedge reset_i) begin
                if (reset_i) begin
                    running_q <= 1'b0;
                    period_q  <= '0;
                    phase_q   <= '0;
                    count_q   <= '0;
                    strobe_q  <= 1'b0;
                    toggle_q  <= 1'b0;
                end else begin
                    running_q <= running_d;
                    period_q  <= period_d;
                    phase_q   <= phase_d;
                    count_q   <= count_d;
                    strobe_q  <= strobe_d;
                    toggle_q  <= toggle_d;
                end
            end

            assign strobe_o[i] = strobe_q;
            assign toggle_o[i] = toggle_q;
        end
    endgenerate

    always_comb begin
        cycle_d = sync_restart_i ? '0 : cycle_q + CYCLE_WIDTH'(1);
        wrap_d  = !sync_restart_i && (cycle_q == '1);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ready_q <= 1'b0;
            cycle_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            cycle_q <= cycle_d;
            wrap_q  <= wrap_d;
        end
    end
endmodule

// File: tb/tb_periodic_strobe_generator.sv
// tb_periodic_strobe_generator: directed checks of strobe timing, restart, wrap and reset.
// A second instance with 3 channels and a 4-bit counter covers out-of-range writes and wrap.
module tb_periodic_strobe_generator;
    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        config_valid_i = 1'b0;
    logic [1:0]  config_channel_i = '0;
    logic [15:0] config_period_i = '0;
    logic [15:0] config_phase_i = '0;
    logic        config_enable_i = 1'b0;
    logic        sync_restart_i = 1'b0;
    logic        ready1, ready2, wrap1, wrap2;
    logic [3:0]  strobe1, toggle1;
    logic [2:0]  strobe2, toggle2;
    logic [31:0] cycle1;
    logic [3:0]  cycle2;
    int checks = 0;
    int failures = 0;

    periodic_strobe_generator dut1 (
        .clock_i(clock_i), .reset_i(reset_i), .config_valid_i(config_valid_i),
        .config_ready_o(ready1), .config_channel_i(config_channel_i),
        .config_period_i(config_period_i), .config_phase_i(config_phase_i),
        .config_enable_i(config_enable_i), .sync_restart_i(sync_restart_i),
        .strobe_o(strobe1), .toggle_o(toggle1), .cycle_o(cycle1), .cycle_wrap_o(wrap1)
    );

    periodic_strobe_generator #(.CHANNEL_COUNT(3), .CYCLE_WIDTH(4)) dut2 (
        .clock_i(clock_i), .reset_i(reset_i), .config_valid_i(config_valid_i),
        .config_ready_o(ready2), .config_channel_i(config_channel_i),
        .config_period_i(config_period_i), .config_phase_i(config_phase_i),
        .config_enable_i(config_enable_i), .sync_restart_i(sync_restart_i),
        .strobe_o(strobe2), .toggle_o(toggle2), .cycle_o(cycle2), .cycle_wrap_o(wrap2)
    );

    always #5 clock_i = ~clock_i;

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [15:0] p, input logic [15:0] f, input logic en);
        config_valid_i   = 1'b1;
        config_channel_i = ch;
        config_period_i  = p;
        config_phase_i   = f;
        config_enable_i  = en;
        tick();
        config_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (ready1 !== 1'b0 || ready2 !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b/%b exp=0/0", ready1, ready2); end
        checks++; if ({strobe1, toggle1, cycle1, wrap1} !== 41'd0) begin failures++; $display("FAIL reset_outputs strobe=%h toggle=%h cycle=%0d wrap=%b exp all 0", strobe1, toggle1, cycle1, wrap1); end
        reset_i = 1'b0;
        #2;
        checks++; if (ready1 !== 1'b0) begin failures++; $display("FAIL ready_before_edge got=%b exp=0", ready1); end
        for (int j = 1; j <= 3; j++) begin
            tick();
            checks++; if (ready1 !== 1'b1 || ready2 !== 1'b1) begin failures++; $display("FAIL ready_after_release j=%0d got=%b/%b exp=1/1", j, ready1, ready2); end
            checks++; if (cycle1 !== 32'(j) || strobe1 !== 4'd0 || toggle1 !== 4'd0) begin failures++; $display("FAIL cycle_count j=%0d cycle=%0d strobe=%h toggle=%h exp cycle=%0d strobe=0 toggle=0", j, cycle1, strobe1, toggle1, j); end
        end
    endtask

    task automatic test_out_of_range_and_p0();
        cfg(2'd3, 16'd1, 16'd0, 1'b1);
        checks++; if (strobe1 !== 4'd0) begin failures++; $display("FAIL p1_at_accept strobe=%h exp=0", strobe1); end
        for (int j = 1; j <= 4; j++) begin
            tick();
            checks++; if (strobe1 !== 4'b1000 || toggle1 !== {j[0], 3'b000}) begin failures++; $display("FAIL p1_ch3 j=%0d strobe=%h toggle=%h exp strobe=8 toggle=%h", j, strobe1, toggle1, {j[0], 3'b000}); end
            checks++; if (strobe2 !== 3'd0 || toggle2 !== 3'd0) begin failures++; $display("FAIL out_of_range j=%0d strobe=%h toggle=%h exp 0/0", j, strobe2, toggle2); end
        end
        cfg(2'd3, 16'd0, 16'd0, 1'b1);
        for (int j = 0; j <= 4; j++) begin
            checks++; if (strobe1 !== 4'd0 || toggle1 !== 4'd0) begin failures++; $display("FAIL p0_stop j=%0d strobe=%h toggle=%h exp 0/0", j, strobe1, toggle1); end
            tick();
        end
    endtask

    task automatic test_period4();
        logic s, t;
        cfg(2'd0, 16'd4, 16'd0, 1'b1);
        checks++; if (strobe1 !== 4'd0 || toggle1 !== 4'd0) begin failures++; $display("FAIL p4_at_accept strobe=%h toggle=%h exp 0/0", strobe1, toggle1); end
        for (int j = 1; j <= 9; j++) begin
            tick();
            s = ((j - 1) % 4) == 0;
            t = (((j - 1) / 4) % 2) == 0;
            checks++; if (strobe1 !== {3'b000, s} || toggle1 !== {3'b000, t}) begin failures++; $display("FAIL p4_ch0 j=%0d strobe=%h toggle=%h exp strobe=%h toggle=%h", j, strobe1, toggle1, {3'b000, s}, {3'b000, t}); end
        end
    endtask

    task automatic test_restart_channels();
        logic [3:0] es, et;
        cfg(2'd1, 16'd3, 16'd5, 1'b1);
        cfg(2'd2, 16'd1, 16'd0, 1'b1);
        sync_restart_i = 1'b1;
        tick();
        sync_restart_i = 1'b0;
        et = 4'd0;
        checks++; if (strobe1 !== 4'd0 || toggle1 !== 4'd0 || cycle1 !== 32'd0 || wrap1 !== 1'b0) begin failures++; $display("FAIL restart_j0 strobe=%h toggle=%h cycle=%0d wrap=%b exp 0/0/0/0", strobe1, toggle1, cycle1, wrap1); end
        for (int j = 1; j <= 12; j++) begin
            tick();
            es[0] = ((j - 1) % 4) == 0;
            es[1] = (j >= 6) && (((j - 6) % 3) == 0);
            es[2] = 1'b1;
            es[3] = 1'b0;
            et = et ^ es;
            checks++; if (strobe1 !== es || toggle1 !== et || cycle1 !== 32'(j)) begin failures++; $display("FAIL multi_ch j=%0d strobe=%h toggle=%h cycle=%0d exp strobe=%h toggle=%h cycle=%0d", j, strobe1, toggle1, cycle1, es, et, j); end
        end
    endtask

    task automatic test_rewrite_and_stop();
        logic s, t;
        cfg(2'd0, 16'd2, 16'd1, 1'b1);
        checks++; if (strobe1[0] !== 1'b0 || toggle1[0] !== 1'b0) begin failures++; $display("FAIL rewrite_at_accept strobe=%b toggle=%b exp 0/0", strobe1[0], toggle1[0]); end
        for (int j = 1; j <= 6; j++) begin
            tick();
            s = (j >= 2) && (j % 2 == 0);
            t = (((j - 2) / 2) % 2) == 0 && j >= 2;
            checks++; if (strobe1[0] !== s || toggle1[0] !== t) begin failures++; $display("FAIL rewrite_ch0 j=%0d strobe=%b toggle=%b exp %b/%b", j, strobe1[0], toggle1[0], s, t); end
        end
        cfg(2'd0, 16'd2, 16'd1, 1'b0);
        for (int j = 0; j <= 5; j++) begin
            checks++; if (strobe1[0] !== 1'b0 || toggle1[0] !== 1'b0) begin failures++; $display("FAIL stop_ch0 j=%0d strobe=%b toggle=%b exp 0/0", j, strobe1[0], toggle1[0]); end
            tick();
        end
    endtask

    task automatic test_wrap();
        sync_restart_i = 1'b1;
        tick();
        sync_restart_i = 1'b0;
        checks++; if (cycle2 !== 4'd0 || wrap2 !== 1'b0) begin failures++; $display("FAIL wrap_restart cycle=%0d wrap=%b exp 0/0", cycle2, wrap2); end
        for (int j = 1; j <= 17; j++) begin
            tick();
            checks++; if (cycle2 !== 4'(j) || wrap2 !== (j == 16) || wrap1 !== 1'b0) begin failures++; $display("FAIL wrap j=%0d cycle=%0d wrap=%b wrap1=%b exp cycle=%0d wrap=%b wrap1=0", j, cycle2, wrap2, wrap1, j % 16, j == 16); end
        end
        repeat (6) tick();
        checks++; if (cycle2 !== 4'd7) begin failures++; $display("FAIL wrap_pre_restart cycle=%0d exp 7", cycle2); end
        sync_restart_i = 1'b1;
        tick();
        sync_restart_i = 1'b0;
        checks++; if (cycle2 !== 4'd0 || wrap2 !== 1'b0 || cycle1 !== 32'd0 || wrap1 !== 1'b0) begin failures++; $display("FAIL restart_at_7 cycle=%0d wrap=%b cycle1=%0d wrap1=%b exp 0/0/0/0", cycle2, wrap2, cycle1, wrap1); end
    endtask

    task automatic test_async_reset();
        repeat (3) tick();
        checks++; if (strobe1[2] !== 1'b1) begin failures++; $display("FAIL pre_reset_ch2 strobe=%b exp 1", strobe1[2]); end
        #2;
        reset_i = 1'b1;
        #1;
        checks++; if ({strobe1, toggle1, cycle1, wrap1, ready1} !== 42'd0) begin failures++; $display("FAIL async_reset strobe=%h toggle=%h cycle=%0d wrap=%b ready=%b exp all 0", strobe1, toggle1, cycle1, wrap1, ready1); end
        tick();
        reset_i = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            tick();
            checks++; if (strobe1 !== 4'd0 || toggle1 !== 4'd0 || cycle1 !== 32'(j)) begin failures++; $display("FAIL post_reset j=%0d strobe=%h toggle=%h cycle=%0d exp 0/0/%0d", j, strobe1, toggle1, cycle1, j); end
        end
    endtask

    initial begin
        test_reset();
        test_out_of_range_and_p0();
        test_period4();
        test_restart_channels();
        test_rewrite_and_stop();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
